// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Memory-wait FSM encoding, forwarding select codes, default widths.
package pipe_pkg;

  localparam int RA_W_DFLT = 5;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } mst_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/fwd_unit.sv
// EX operand forwarding select for one source register.
// Ports: ex_rs_i, mem_wr_i/mem_rf_we_i, wb_wr_i/wb_rf_we_i in; sel_o out.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int RA_W = RA_W_DFLT
) (
  input  logic [RA_W-1:0] ex_rs_i,
  input  logic [RA_W-1:0] mem_wr_i,
  input  logic            mem_rf_we_i,
  input  logic [RA_W-1:0] wb_wr_i,
  input  logic            wb_rf_we_i,
  output logic [1:0]      sel_o
);

  logic mem_hit;
  logic wb_hit;

  // x0 is hard-wired zero, never a forwarding source
  assign mem_hit = mem_rf_we_i
                 & (mem_wr_i != '0)
                 & (mem_wr_i == ex_rs_i);
  assign wb_hit  = wb_rf_we_i
                 & (wb_wr_i != '0)
                 & (wb_wr_i == ex_rs_i);

  // MEM holds the younger result
  always_comb begin
    sel_o = FWD_RF;
    if (mem_hit)     sel_o = FWD_MEM;
    else if (wb_hit) sel_o = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding control for the 5-stage pipeline registers.
// In: ID/EX/MEM/WB reg info, branch, DRAM req/ack. Out: holds, flushes, fwd, status.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RA_W    = RA_W_DFLT,
  parameter int MEM_TMO = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_re1,
  input  logic             id_re2,
  input  logic [RA_W-1:0]  ex_rs1,
  input  logic [RA_W-1:0]  ex_rs2,
  input  logic [RA_W-1:0]  ex_wr,
  input  logic             ex_rf_we,
  input  logic             ex_is_load,
  input  logic             ex_br_taken,
  input  logic [RA_W-1:0]  mem_wr,
  input  logic             mem_rf_we,
  input  logic [RA_W-1:0]  wb_wr,
  input  logic             wb_rf_we,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_flush,
  output logic             exmem_hold,
  output logic             memwb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_busy,
  output logic             tmo_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WC_W = $clog2(MEM_TMO + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TMO - 1);

  mst_e             state_q;
  logic [WC_W-1:0]  wait_q;
  logic             tmo_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;

  logic mem_stall;
  logic lu;

  assign mem_stall = (state_q == ST_RUN  & mem_req & ~mem_ack)
                   | (state_q == ST_WAIT & ~mem_ack)
                   | (state_q == ST_ERR);

  assign lu = ex_is_load & ex_rf_we & (ex_wr != '0)
            & ((id_re1 & (id_rs1 == ex_wr))
             | (id_re2 & (id_rs2 == ex_wr)));

  // Priority: memory stall, then taken branch, then load-use.
  // A taken branch makes the ID instr wrong-path, so lu is moot.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_flush  = 1'b0;
    exmem_hold  = 1'b0;
    memwb_flush = 1'b0;
    if (mem_stall) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_hold   = 1'b1;
      exmem_hold  = 1'b1;
      memwb_flush = 1'b1;
    end else if (ex_br_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (lu) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_flush  = 1'b1;
    end
  end

  fwd_unit #(.RA_W(RA_W)) u_fwd_a (
    .ex_rs_i     (ex_rs1),
    .mem_wr_i    (mem_wr),
    .mem_rf_we_i (mem_rf_we),
    .wb_wr_i     (wb_wr),
    .wb_rf_we_i  (wb_rf_we),
    .sel_o       (fwd_a)
  );

  fwd_unit #(.RA_W(RA_W)) u_fwd_b (
    .ex_rs_i     (ex_rs2),
    .mem_wr_i    (mem_wr),
    .mem_rf_we_i (mem_rf_we),
    .wb_wr_i     (wb_wr),
    .wb_rf_we_i  (wb_rf_we),
    .sel_o       (fwd_b)
  );

  // ERR is terminal until reset; ack is ignored there
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (mem_req & ~mem_ack) begin
            state_q <= ST_WAIT;
            wait_q  <= WC_W'(1);
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
          end else if (wait_q == WC_LAST) begin
            state_q <= ST_ERR;
            tmo_q   <= 1'b1;
          end else begin
            wait_q  <= wait_q + WC_W'(1);
          end
        end
        ST_ERR: begin
          state_q <= ST_ERR;
        end
        default: begin
          state_q <= ST_RUN;
          wait_q  <= '0;
        end
      endcase
    end
  end

  assign stall_d = pc_hold ? stall_q + CNT_W'(1)
                           : stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign mem_busy  = (state_q == ST_WAIT);
  assign tmo_err   = tmo_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Inputs change 1ns after posedge; outputs checked mid-cycle.
module tb_pipe_hazard_ctrl;

  localparam int RA_W  = 5;
  localparam int CNT_W = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [RA_W-1:0]  id_rs1, id_rs2;
  logic             id_re1, id_re2;
  logic [RA_W-1:0]  ex_rs1, ex_rs2, ex_wr;
  logic             ex_rf_we, ex_is_load, ex_br_taken;
  logic [RA_W-1:0]  mem_wr, wb_wr;
  logic             mem_rf_we, wb_rf_we;
  logic             mem_req, mem_ack;
  logic             pc_hold, ifid_hold, ifid_flush;
  logic             idex_hold, idex_flush;
  logic             exmem_hold, memwb_flush;
  logic [1:0]       fwd_a, fwd_b;
  logic             mem_busy, tmo_err;
  logic [CNT_W-1:0] stall_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl #(
    .RA_W(RA_W), .MEM_TMO(4), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_re1(id_re1), .id_re2(id_re2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_wr(ex_wr), .ex_rf_we(ex_rf_we),
    .ex_is_load(ex_is_load),
    .ex_br_taken(ex_br_taken),
    .mem_wr(mem_wr), .mem_rf_we(mem_rf_we),
    .wb_wr(wb_wr), .wb_rf_we(wb_rf_we),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold),
    .ifid_flush(ifid_flush),
    .idex_hold(idex_hold),
    .idex_flush(idex_flush),
    .exmem_hold(exmem_hold),
    .memwb_flush(memwb_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_busy(mem_busy), .tmo_err(tmo_err),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst_i = 1'b0;
    id_rs1 = '0; id_rs2 = '0;
    id_re1 = 1'b0; id_re2 = 1'b0;
    ex_rs1 = '0; ex_rs2 = '0; ex_wr = '0;
    ex_rf_we = 1'b0; ex_is_load = 1'b0;
    ex_br_taken = 1'b0;
    mem_wr = '0; wb_wr = '0;
    mem_rf_we = 1'b0; wb_rf_we = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  // advance one cycle, then let comb outputs settle
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_lu();
    ex_is_load = 1'b1; ex_rf_we = 1'b1;
    ex_wr = 5'd5; id_rs1 = 5'd5; id_re1 = 1'b1;
  endtask

  task automatic chk_holds(input string tag,
                           input logic v);
    chk({tag, ".pc"},    32'(pc_hold),     32'(v));
    chk({tag, ".ifid"},  32'(ifid_hold),   32'(v));
    chk({tag, ".idex"},  32'(idex_hold),   32'(v));
    chk({tag, ".exmem"}, 32'(exmem_hold),  32'(v));
    chk({tag, ".mwbf"},  32'(memwb_flush), 32'(v));
  endtask

  initial begin
    idle();
    rst_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
    #1;
    chk_holds("rst", 1'b0);
    chk("rst.busy", 32'(mem_busy), 0);
    chk("rst.tmo",  32'(tmo_err), 0);
    chk("rst.cnt",  stall_cnt, 0);

    // T1 load-use
    set_lu(); #1;
    chk("t1.pc",    32'(pc_hold), 1);
    chk("t1.ifidh", 32'(ifid_hold), 1);
    chk("t1.idexf", 32'(idex_flush), 1);
    chk("t1.idexh", 32'(idex_hold), 0);
    chk("t1.ifidf", 32'(ifid_flush), 0);
    step();
    idle(); #1;
    chk("t1.rel",   32'(pc_hold), 0);
    chk("t1.relf",  32'(idex_flush), 0);
    chk("t1.cnt",   stall_cnt, 1);

    set_lu(); id_re1 = 1'b0; #1;
    chk("lu.nore",  32'(pc_hold), 0);
    id_re1 = 1'b0; id_re2 = 1'b1; id_rs2 = 5'd5; #1;
    chk("lu.rs2",   32'(pc_hold), 1);
    idle(); set_lu(); ex_wr = '0; id_rs1 = '0; #1;
    chk("lu.x0",    32'(pc_hold), 0);
    idle(); set_lu(); ex_is_load = 1'b0; #1;
    chk("lu.noload", 32'(pc_hold), 0);

    // T2 branch beats load-use
    idle(); set_lu(); ex_br_taken = 1'b1; #1;
    chk("t2.ifidf", 32'(ifid_flush), 1);
    chk("t2.idexf", 32'(idex_flush), 1);
    chk("t2.pc",    32'(pc_hold), 0);
    chk("t2.ifidh", 32'(ifid_hold), 0);
    step();
    idle(); #1;
    chk("t2.cnt",   stall_cnt, 1);

    // T5 forwarding
    ex_rs1 = 5'd7; ex_rs2 = 5'd7;
    mem_wr = 5'd7; wb_wr = 5'd7;
    mem_rf_we = 1'b1; wb_rf_we = 1'b1; #1;
    chk("t5.a.mem", 32'(fwd_a), 32'h1);
    chk("t5.b.mem", 32'(fwd_b), 32'h1);
    mem_rf_we = 1'b0; #1;
    chk("t5.a.wb",  32'(fwd_a), 32'h2);
    chk("t5.b.wb",  32'(fwd_b), 32'h2);
    ex_rs2 = 5'd3; #1;
    chk("t5.b.miss", 32'(fwd_b), 32'h0);
    mem_rf_we = 1'b1; mem_wr = 5'd3; #1;
    chk("t5.a.wb2", 32'(fwd_a), 32'h2);
    chk("t5.b.mem2", 32'(fwd_b), 32'h1);
    ex_rs1 = '0; ex_rs2 = '0;
    mem_wr = '0; wb_wr = '0; #1;
    chk("t5.a.x0",  32'(fwd_a), 32'h0);
    chk("t5.b.x0",  32'(fwd_b), 32'h0);
    idle(); #1;

    // T3 three wait states, branch masked
    mem_req = 1'b1; ex_br_taken = 1'b1; #1;
    chk_holds("t3.c1", 1'b1);
    chk("t3.c1.ifidf", 32'(ifid_flush), 0);
    chk("t3.c1.busy",  32'(mem_busy), 0);
    step();
    ex_br_taken = 1'b0; #1;
    chk_holds("t3.c2", 1'b1);
    chk("t3.c2.busy", 32'(mem_busy), 1);
    step();
    chk("t3.c3.pc",   32'(pc_hold), 1);
    chk("t3.c3.busy", 32'(mem_busy), 1);
    step();
    mem_ack = 1'b1; #1;
    chk_holds("t3.c4", 1'b0);
    chk("t3.c4.busy", 32'(mem_busy), 1);
    step();
    idle(); #1;
    chk("t3.busy", 32'(mem_busy), 0);
    chk("t3.cnt",  stall_cnt, 4);

    // zero-wait access
    mem_req = 1'b1; mem_ack = 1'b1; #1;
    chk("zw.pc", 32'(pc_hold), 0);
    step();
    idle(); #1;
    chk("zw.busy", 32'(mem_busy), 0);
    chk("zw.cnt",  stall_cnt, 4);

    // T6 reset mid-wait
    mem_req = 1'b1;
    step();
    rst_i = 1'b1; #1;
    chk("t6.busy0", 32'(mem_busy), 1);
    step();
    idle(); #1;
    chk("t6.busy", 32'(mem_busy), 0);
    chk_holds("t6", 1'b0);
    chk("t6.cnt",  stall_cnt, 0);

    // T4 timeout with MEM_TMO=4
    mem_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("t4.c%0d.tmo", i),
          32'(tmo_err), 0);
      chk($sformatf("t4.c%0d.pc", i),
          32'(pc_hold), 1);
      step();
    end
    #1;
    chk("t4.tmo",  32'(tmo_err), 1);
    chk("t4.busy", 32'(mem_busy), 0);
    step();
    mem_ack = 1'b1; #1;
    chk_holds("t4.ack", 1'b1);
    step();
    idle(); #1;
    chk("t4.cnt",   stall_cnt, 6);
    chk("t4.idle",  32'(pc_hold), 1);
    chk("t4.tmo2",  32'(tmo_err), 1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; #1;
    chk("t4.rtmo", 32'(tmo_err), 0);
    chk_holds("t4.rst", 1'b0);
    chk("t4.rcnt", stall_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
